serial_logic_sequencer: RTL

Multi-cycle controller that sequences a single 1-bit logic slice (AND/OR/XOR/XNOR gate) over a WIDTH-bit operand pair, one bit per clock, LSB first. It gives the CPU's logic-op path a start/busy/done handshake, so one shared gate cell serves full-word logic instructions. It also produces zero and parity flags for the status register.

---
 rtl/cpu_pkg.sv | 23 ++
 rtl/serial_logic_sequencer_slice.sv | 38 +++
 rtl/xorGate.sv | 18 +
 rtl/serial_logic_sequencer.sv | 107 ++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// ============================================================================
// Module   : cpu_pkg
// Brief    : Shared logic-op encodings and serial sequencer state encodings.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_XOR  = 2'b10;
    localparam logic [1:0] OP_XNOR = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/serial_logic_sequencer_slice.sv
// ============================================================================
// Module   : logic_slice
// Brief    : Combinational 1-bit gate selector (AND/OR/XOR/XNOR).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module logic_slice
    import cpu_pkg::*;
(
    input  logic [1:0] op,
    input  logic       x,
    input  logic       y,
    output logic       z
);

    logic w_xor;

    xorGate u_xor (
        .a (x),
        .b (y),
        .y (w_xor)
    );

    always_comb begin
        z = w_xor;
        case (op)
            OP_AND:  z = x & y;
            OP_OR:   z = x | y;
            OP_XOR:  z = w_xor;
            OP_XNOR: z = ~w_xor;
            default: z = w_xor;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/xorGate.sv
// ============================================================================
// Module   : xorGate
// Brief    : Two-input XOR cell shared across the datapath.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module xorGate (
    input  logic a,
    input  logic b,
    output logic y
);

    assign y = a ^ b;

endmodule

`default_nettype wire

// File: rtl/serial_logic_sequencer.sv
// ============================================================================
// Module   : serial_logic_sequencer
// Brief    : Applies one shared 1-bit logic slice over a WIDTH-bit operand pair,
//            LSB first, with a start/busy/done handshake and zero/parity flags.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_logic_sequencer
    import cpu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             parity
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

    state_t           r_state;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_opa;
    logic [WIDTH-1:0] r_opb;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_result;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;
    logic             w_bit;
    logic [WIDTH-1:0] w_acc_next;

    logic_slice u_slice (
        .op (r_op),
        .x  (r_opa[0]),
        .y  (r_opb[0]),
        .z  (w_bit)
    );

    // Result bits arrive LSB first, so they enter at the MSB and walk down.
    assign w_acc_next = {w_bit, r_acc[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_op     <= OP_AND;
            r_opa    <= '0;
            r_opb    <= '0;
            r_acc    <= '0;
            r_result <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op    <= op;
                        r_opa   <= a;
                        r_opb   <= b;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_acc <= w_acc_next;
                    r_opa <= r_opa >> 1;
                    r_opb <= r_opb >> 1;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == C_LAST) begin
                        r_result <= w_acc_next;
                        r_done   <= 1'b1;
                        r_state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;
    assign zero   = (r_result == '0);
    assign parity = ^r_result;

endmodule

`default_nettype wire
